cmp_sched: RTL

- Scheduler that shares one equality-comparator datapath (enable/done handshake, A/B operands, 1-bit equal result) between NREQ requesters in the proto processor.
- Arbitrates requests round-robin and latches the winner's operands.
- Drives the comparator's enable, waits for its done, and returns the result to the winner with a one-cycle ack.
- Sits between the decode/branch units and the shared comparator.

---
 rtl/cmp_sched_pkg.sv | 34 +++
 rtl/cmp_sched_rr_pick.sv | 23 ++
 rtl/cmp_sched.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/cmp_sched_pkg.sv
// Shared types, default sizes and the round-robin search helper for cmp_sched.
// Optional feature macro: CMP_SCHED_EQCNT_EN (see cmp_sched.sv).
package cmp_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam int NREQ_DEF  = 4;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;
    localparam int MAX_REQ   = 8;

    // Index of the first set bit of req at or after ptr, wrapping modulo nreq.
    // Callers only use the result when req is non-zero.
    function automatic logic [2:0] first_set_from(input logic [MAX_REQ-1:0] req,
                                                  input logic [2:0]         ptr,
                                                  input int                 nreq);
        logic [2:0] idx;
        logic       found;
        first_set_from = 3'd0;
        found          = 1'b0;
        for (int k = 0; k < MAX_REQ; k++) begin
            idx = 3'((int'(ptr) + k) % nreq);
            if (!found && (k < nreq) && req[idx]) begin
                first_set_from = idx;
                found          = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/cmp_sched_rr_pick.sv
// Combinational round-robin picker: first asserted request at or after ptr.
module rr_pick
    import cmp_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int PTR_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic             gnt_valid,
    output logic [PTR_W-1:0] gnt_id
);

    logic [MAX_REQ-1:0] req_ext;

    always_comb begin
        req_ext             = '0;
        req_ext[NREQ-1:0]   = req;
        gnt_valid           = |req;
        gnt_id              = PTR_W'(first_set_from(req_ext, 3'(ptr), NREQ));
    end

endmodule

// File: rtl/cmp_sched.sv
// Round-robin scheduler sharing one equality comparator among NREQ requesters.
// Optional feature: define CMP_SCHED_EQCNT_EN to add the eq_count output.
module cmp_sched
    import cmp_sched_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_bus,
    input  logic [NREQ*WIDTH-1:0] b_bus,
    output logic [NREQ-1:0]       ack,
    output logic                  eq_out,
    output logic                  busy,
    output logic                  cmp_enable,
    output logic [WIDTH-1:0]      cmp_a,
    output logic [WIDTH-1:0]      cmp_b,
    input  logic                  cmp_done,
    input  logic                  cmp_eq
`ifdef CMP_SCHED_EQCNT_EN
    ,
    output logic [CNT_W-1:0]      eq_count
`endif
);

    localparam int PTR_W = $clog2(NREQ);

    state_t           state;
    state_t           state_nxt;
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] grant_id;
    logic [PTR_W-1:0] ptr_nxt;
    logic             result;
    logic             gnt_valid;
    logic [PTR_W-1:0] gnt_id;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req       (req),
        .ptr       (ptr),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Operand slices of the requester the picker currently selects.
    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_id == PTR_W'(i)) begin
                a_sel = a_bus[i*WIDTH +: WIDTH];
                b_sel = b_bus[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        if (grant_id == PTR_W'(NREQ - 1)) begin
            ptr_nxt = '0;
        end else begin
            ptr_nxt = grant_id + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs are pure state decodes so they drop asynchronously with rst_n.
    always_comb begin
        state_nxt  = state;
        cmp_enable = 1'b0;
        busy       = 1'b0;
        ack        = '0;
        eq_out     = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                busy       = 1'b1;
                cmp_enable = 1'b1;
                if (cmp_done) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                busy          = 1'b1;
                ack[grant_id] = 1'b1;
                eq_out        = result;
                state_nxt     = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Operands are sampled only at the grant edge; done outside ISSUE is ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            grant_id <= '0;
            result   <= 1'b0;
            cmp_a    <= '0;
            cmp_b    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_valid) begin
                        grant_id <= gnt_id;
                        cmp_a    <= a_sel;
                        cmp_b    <= b_sel;
                    end
                end
                ISSUE: begin
                    if (cmp_done) begin
                        result <= cmp_eq;
                    end
                end
                RESP: begin
                    ptr <= ptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

`ifdef CMP_SCHED_EQCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eq_count <= '0;
        end else if ((state == RESP) && result) begin
            eq_count <= eq_count + CNT_W'(1);
        end
    end
`endif

endmodule
